// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register pending (scoreboard) bits.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*XLEN-1:0]   wr_data,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_addr,
  output logic [AW:0]           busy_cnt,
  output logic [NREGS*XLEN-1:0] snap
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] pending_q, pending_d;
  logic [AW:0]      busy_cnt_q, busy_cnt_d;

  // Ports are applied in ascending order so the highest-index port wins a conflict.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && (wr_addr[p*AW +: AW] != '0)) begin
        regs_d[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
      end
    end
    regs_d[0] = '0;
  end

  // Clears first, then the issue sets, so a new producer survives a same-edge writeback.
  always_comb begin
    pending_d = pending_q;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p]) begin
        pending_d[wr_addr[p*AW +: AW]] = 1'b0;
      end
    end
    if (iss_valid) begin
      pending_d[iss_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int r = 1; r < NREGS; r++) begin
      busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, pending_d[r]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      pending_q  <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      pending_q  <= pending_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = rd_addr[k*AW +: AW];

    always_comb begin
      data = regs_q[addr];
      busy = pending_q[addr];
`ifdef REGFILE_BYPASS_EN
      // Gated by rst so the read ports stay at zero while reset is held.
      if (!rst && (addr != '0)) begin
        for (int p = 0; p < NWR; p++) begin
          if (wr_en[p] && (wr_addr[p*AW +: AW] == addr)) begin
            data = wr_data[p*XLEN +: XLEN];
            busy = 1'b0;
          end
        end
      end
`endif
      if (addr == '0) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data[k*XLEN +: XLEN] = data;
    assign rd_busy[k]              = busy;
  end

  assign snap[XLEN-1:0] = '0;
  for (genvar r = 1; r < NREGS; r++) begin : g_snap
    assign snap[r*XLEN +: XLEN] = regs_q[r];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: vector table with a scoreboard queue, plus snapshot and reset sequences.
module tb_regfile_mp;
  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*XLEN-1:0]   rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [NWR-1:0]        wr_en;
  logic [NWR*AW-1:0]     wr_addr;
  logic [NWR*XLEN-1:0]   wr_data;
  logic                  iss_valid;
  logic [AW-1:0]         iss_addr;
  logic [AW:0]           busy_cnt;
  logic [NREGS*XLEN-1:0] snap;

  int checks = 0;
  int errors = 0;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .busy_cnt  (busy_cnt),
    .snap      (snap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [63:0] wd0;
    logic [4:0]  wa1;
    logic [63:0] wd1;
    logic        iv;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [63:0] ed0;
    logic        eb0;
    logic [63:0] ed1;
    logic        eb1;
    logic [5:0]  ecnt;
  } vec_t;

  typedef struct {
    logic [63:0] d0;
    logic        b0;
    logic [63:0] d1;
    logic        b1;
    logic [5:0]  cnt;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[20];

  function automatic vec_t mk(input logic [1:0] we, input logic [4:0] wa0, input logic [63:0] wd0,
                              input logic [4:0] wa1, input logic [63:0] wd1, input logic iv,
                              input logic [4:0] ia, input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic [63:0] ed0, input logic eb0, input logic [63:0] ed1,
                              input logic eb1, input logic [5:0] ecnt);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1; v.iv = iv; v.ia = ia;
    v.ra0 = ra0; v.ra1 = ra1; v.ed0 = ed0; v.eb0 = eb0; v.ed1 = ed1; v.eb1 = eb1; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wr_en     = v.we;
    wr_addr   = {v.wa1, v.wa0};
    wr_data   = {v.wd1, v.wd0};
    iss_valid = v.iv;
    iss_addr  = v.ia;
    rd_addr   = {v.ra1, v.ra0};
  endtask

  task automatic idle();
    wr_en     = '0;
    iss_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [63:0] z;
    z = 64'h0;

    // Register contents along the table: x5=1234, x7=BB, x3=55, x4=44->77, x9=99->1, x12, x20.
    tbl[0]  = mk(2'b00, 5'd0, z, 5'd0, z, 1'b0, 5'd0, 5'd0, 5'd1, z, 1'b0, z, 1'b0, 6'd0);
    tbl[1]  = mk(2'b01, 5'd5, 64'h1234, 5'd0, z, 1'b0, 5'd0, 5'd5, 5'd0,
                 BYP ? 64'h1234 : z, 1'b0, z, 1'b0, 6'd0);
    tbl[2]  = mk(2'b00, 5'd0, z, 5'd0, z, 1'b0, 5'd0, 5'd5, 5'd0, 64'h1234, 1'b0, z, 1'b0, 6'd0);
    tbl[3]  = mk(2'b01, 5'd0, 64'hFFFF, 5'd0, z, 1'b1, 5'd0, 5'd0, 5'd0, z, 1'b0, z, 1'b0, 6'd0);
    tbl[4]  = mk(2'b00, 5'd0, z, 5'd0, z, 1'b0, 5'd0, 5'd0, 5'd0, z, 1'b0, z, 1'b0, 6'd0);
    tbl[5]  = mk(2'b11, 5'd7, 64'hAA, 5'd7, 64'hBB, 1'b0, 5'd0, 5'd7, 5'd7,
                 BYP ? 64'hBB : z, 1'b0, BYP ? 64'hBB : z, 1'b0, 6'd0);
    tbl[6]  = mk(2'b00, 5'd0, z, 5'd0, z, 1'b0, 5'd0, 5'd7, 5'd7, 64'hBB, 1'b0, 64'hBB, 1'b0, 6'd0);
    tbl[7]  = mk(2'b00, 5'd0, z, 5'd0, z, 1'b1, 5'd3, 5'd3, 5'd5, z, 1'b0, 64'h1234, 1'b0, 6'd1);
    tbl[8]  = mk(2'b00, 5'd0, z, 5'd0, z, 1'b0, 5'd0, 5'd3, 5'd5, z, 1'b1, 64'h1234, 1'b0, 6'd1);
    tbl[9]  = mk(2'b10, 5'd0, z, 5'd3, 64'h55, 1'b0, 5'd0, 5'd3, 5'd3,
                 BYP ? 64'h55 : z, ~BYP, BYP ? 64'h55 : z, ~BYP, 6'd0);
    tbl[10] = mk(2'b00, 5'd0, z, 5'd0, z, 1'b0, 5'd0, 5'd3, 5'd0, 64'h55, 1'b0, z, 1'b0, 6'd0);
    tbl[11] = mk(2'b10, 5'd0, z, 5'd4, 64'h44, 1'b1, 5'd9, 5'd9, 5'd4,
                 z, 1'b0, BYP ? 64'h44 : z, 1'b0, 6'd1);
    tbl[12] = mk(2'b01, 5'd9, 64'h99, 5'd0, z, 1'b1, 5'd9, 5'd9, 5'd0,
                 BYP ? 64'h99 : z, ~BYP, z, 1'b0, 6'd1);
    tbl[13] = mk(2'b00, 5'd0, z, 5'd0, z, 1'b0, 5'd0, 5'd9, 5'd4, 64'h99, 1'b1, 64'h44, 1'b0, 6'd1);
    tbl[14] = mk(2'b00, 5'd0, z, 5'd0, z, 1'b1, 5'd4, 5'd4, 5'd9, 64'h44, 1'b0, 64'h99, 1'b1, 6'd2);
    tbl[15] = mk(2'b01, 5'd4, 64'h77, 5'd0, z, 1'b0, 5'd0, 5'd4, 5'd4,
                 BYP ? 64'h77 : 64'h44, ~BYP, BYP ? 64'h77 : 64'h44, ~BYP, 6'd1);
    tbl[16] = mk(2'b11, 5'd9, 64'h1, 5'd12, 64'h2, 1'b1, 5'd12, 5'd9, 5'd12,
                 BYP ? 64'h1 : 64'h99, ~BYP, BYP ? 64'h2 : z, 1'b0, 6'd1);
    tbl[17] = mk(2'b00, 5'd0, z, 5'd0, z, 1'b1, 5'd20, 5'd12, 5'd9, 64'h2, 1'b1, 64'h1, 1'b0, 6'd2);
    tbl[18] = mk(2'b11, 5'd12, 64'h3, 5'd20, 64'h4, 1'b0, 5'd0, 5'd4, 5'd9,
                 64'h77, 1'b0, 64'h1, 1'b0, 6'd0);
    tbl[19] = mk(2'b00, 5'd0, z, 5'd0, z, 1'b0, 5'd0, 5'd12, 5'd20, 64'h3, 1'b0, 64'h4, 1'b0, 6'd0);

    rst = 1'b1;
    drive(tbl[0]);
    @(negedge clk);
    chk("reset_busy_cnt", 64'(busy_cnt), z);
    chk("reset_rd_data", rd_data[63:0], z);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      sbq.push_back('{d0: tbl[i].ed0, b0: tbl[i].eb0, d1: tbl[i].ed1, b1: tbl[i].eb1,
                      cnt: tbl[i].ecnt});
      #1;
      e = sbq.pop_front();
      chk($sformatf("v%0d_rd_data0", i), rd_data[63:0], e.d0);
      chk($sformatf("v%0d_rd_busy0", i), 64'(rd_busy[0]), 64'(e.b0));
      chk($sformatf("v%0d_rd_data1", i), rd_data[127:64], e.d1);
      chk($sformatf("v%0d_rd_busy1", i), 64'(rd_busy[1]), 64'(e.b1));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_busy_cnt", i), 64'(busy_cnt), 64'(e.cnt));
    end

    // Snapshot follows the committed array only, never the bypass path.
    @(negedge clk);
    idle();
    rd_addr = {5'd0, 5'd5};
    #1;
    chk("snap_x0", snap[0 +: 64], z);
    chk("snap_x5", snap[5*64 +: 64], 64'h1234);
    chk("snap_x7", snap[7*64 +: 64], 64'hBB);
    chk("snap_x12", snap[12*64 +: 64], 64'h3);
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd5};
    wr_data = {z, 64'h999};
    #1;
    chk("snap_prewrite_x5", snap[5*64 +: 64], 64'h1234);
    chk("bypass_read_x5", rd_data[63:0], BYP ? 64'h999 : 64'h1234);
    @(posedge clk);
    #1;
    chk("snap_postwrite_x5", snap[5*64 +: 64], 64'h999);

    // Mid-cycle asynchronous reset with a pending register and writes/issues held active.
    @(negedge clk);
    idle();
    iss_valid = 1'b1;
    iss_addr  = 5'd6;
    @(posedge clk);
    #1;
    chk("pre_reset_busy_cnt", 64'(busy_cnt), 64'd1);
    @(negedge clk);
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd5};
    wr_data = {z, 64'hDEAD};
    rd_addr = {5'd6, 5'd5};
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_rd_data", rd_data[63:0], z);
    chk("async_reset_rd_busy", 64'(rd_busy), z);
    chk("async_reset_busy_cnt", 64'(busy_cnt), z);
    @(posedge clk);
    #1;
    chk("reset_edge_snap_x5", snap[5*64 +: 64], z);
    @(negedge clk);
    idle();
    rst = 1'b0;
    #1;
    chk("post_reset_x5", rd_data[63:0], z);
    chk("post_reset_busy_cnt", 64'(busy_cnt), z);
    wr_en   = 2'b10;
    wr_addr = {5'd5, 5'd0};
    wr_data = {64'h1, z};
    @(posedge clk);
    #1;
    chk("first_write_after_reset", snap[5*64 +: 64], 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
